// File: rtl/goertzel_bin_scheduler.sv
// Goertzel bin scheduler: walks the enabled bins of a frame through one shared
// goertzel_loop_core and hands each bin's T1/T2 downstream over valid/ready.
module goertzel_bin_scheduler #(
  parameter int D_W      = 16,
  parameter int NUM_BINS = 4,
  parameter int BIN_W    = 2,
  parameter int TIMEOUT  = 2048
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                frame_ready,
  input  logic [NUM_BINS-1:0] bin_mask,
  input  logic                cfg_we,
  input  logic [BIN_W-1:0]    cfg_addr,
  input  logic [D_W-1:0]      cfg_coeff,
  output logic                core_enable,
  output logic                core_start,
  output logic [D_W-1:0]      core_coeff,
  input  logic                core_done,
  input  logic [D_W-1:0]      core_T1,
  input  logic [D_W-1:0]      core_T2,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BIN_W-1:0]    res_bin,
  output logic [D_W-1:0]      res_T1,
  output logic [D_W-1:0]      res_T2,
  output logic                busy,
  output logic                sweep_done,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int IDX_W = BIN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_LOAD, S_START, S_WAIT, S_EMIT, S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [BIN_W-1:0]      idx_lo;
  logic [NUM_BINS-1:0]   mask_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [D_W-1:0]        coeff_tbl [NUM_BINS];
  logic                  idx_in_range;
  logic                  wait_expired;
  logic                  cfg_addr_ok;

  // idx is one bit wider than a bin index so it can step past the last bin
  assign idx_lo       = idx_q[BIN_W-1:0];
  assign idx_in_range = 32'(idx_q) < 32'(NUM_BINS);
  assign wait_expired = wait_cnt_q == CNT_W'(TIMEOUT - 1);
  assign cfg_addr_ok  = 32'(cfg_addr) < 32'(NUM_BINS);
  assign core_enable  = busy;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) coeff_tbl[i] <= '0;
    end else if (cfg_we && cfg_addr_ok) begin
      coeff_tbl[cfg_addr] <= cfg_coeff;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      S_IDLE:   if (frame_ready) state_d = S_SCAN;
      S_SCAN: begin
        if (!idx_in_range)       state_d = S_FINISH;
        else if (mask_q[idx_lo]) state_d = S_LOAD;
      end
      S_LOAD:   state_d = S_START;
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done)         state_d = S_EMIT;
        else if (wait_expired) state_d = S_SCAN;
      end
      S_EMIT:   if (res_ready) state_d = S_SCAN;
      S_FINISH: begin
        sweep_done = 1'b1;
        state_d    = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q       <= '0;
      mask_q      <= '0;
      wait_cnt_q  <= '0;
      core_coeff  <= '0;
      res_valid   <= 1'b0;
      res_bin     <= '0;
      res_T1      <= '0;
      res_T2      <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // a frame arriving mid-sweep is dropped and only flagged
      overrun <= frame_ready && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (frame_ready) begin
            mask_q      <= bin_mask;
            idx_q       <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_SCAN: begin
          if (idx_in_range && !mask_q[idx_lo]) idx_q <= idx_q + 1'b1;
        end
        S_LOAD:  core_coeff <= coeff_tbl[idx_lo];
        S_START: wait_cnt_q <= '0;
        S_WAIT: begin
          if (core_done) begin
            res_T1    <= core_T1;
            res_T2    <= core_T2;
            res_bin   <= idx_lo;
            res_valid <= 1'b1;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            idx_q       <= idx_q + 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            idx_q     <= idx_q + 1'b1;
          end
        end
        S_FINISH: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Bench for goertzel_bin_scheduler: behavioural core model plus queue-based
// scoreboard of expected core starts and results per frame.
module tb_goertzel_bin_scheduler;

  logic        sys_clk, sys_rst_n, frame_ready, cfg_we, core_done, res_ready;
  logic [3:0]  bin_mask;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_coeff, core_T1, core_T2;
  logic        core_enable, core_start, res_valid, busy, sweep_done, overrun, timeout_err;
  logic [15:0] core_coeff, res_T1, res_T2;
  logic [1:0]  res_bin;

  goertzel_bin_scheduler #(.D_W(16), .NUM_BINS(4), .BIN_W(2), .TIMEOUT(2048)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_ready(frame_ready),
    .bin_mask(bin_mask), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coeff(cfg_coeff),
    .core_enable(core_enable), .core_start(core_start), .core_coeff(core_coeff),
    .core_done(core_done), .core_T1(core_T1), .core_T2(core_T2),
    .res_valid(res_valid), .res_ready(res_ready), .res_bin(res_bin),
    .res_T1(res_T1), .res_T2(res_T2), .busy(busy), .sweep_done(sweep_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  typedef struct {
    int          bin;
    logic [15:0] t1;
    logic [15:0] t2;
  } res_t;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  logic [15:0] tbl_model [4];
  int          start_q[$], core_bin_q[$], start_cyc[$];
  res_t        res_q[$];
  int          hang_bin = -1, core_delay = 1, ready_mode = 0;
  logic [15:0] frame_salt = '0;
  logic [3:0]  cur_mask;
  int          fp, n_starts = 0, n_res = 0, n_valid = 0, n_sweeps = 0;
  int          st0, rs0, v0, sw0;
  bit          hold_prev = 0;
  logic [33:0] held;
  int          core_b;
  bit          core_abort;

  initial begin
    sys_clk = 0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] t_val(input int bin, input int k, input logic [15:0] salt);
    return 16'(bin * 256 + k) ^ salt;
  endfunction

  // Core model: done pulse core_delay cycles after start, or never for hang_bin
  initial begin
    core_done = 0; core_T1 = '0; core_T2 = '0;
    forever begin
      @(posedge sys_clk);
      if (core_bin_q.size() > 0) begin
        core_b = core_bin_q.pop_front();
        if (core_b != hang_bin) begin
          core_abort = 0;
          for (int k = 0; k < core_delay - 1; k++) begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin core_abort = 1; break; end
          end
          if (!core_abort) begin
            #1;
            core_done = 1;
            core_T1 = t_val(core_b, 1, frame_salt);
            core_T2 = t_val(core_b, 2, frame_salt);
            @(posedge sys_clk);
            #1 core_done = 0;
          end
        end
      end
    end
  end

  always @(posedge sys_clk) begin
    #1;
    if (ready_mode == 1) res_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", {res_bin, res_T1, res_T2}, held);
      end
      if (core_start) begin
        start_cyc.push_back(cyc);
        n_starts++;
        checks++;
        assert (start_q.size() != 0) else begin
          errors++;
          $error("FAIL start_unexpected observed=start expected=none coeff=%0h", core_coeff);
        end
        if (start_q.size() != 0) begin
          int b;
          b = start_q.pop_front();
          chk("start_coeff", core_coeff, tbl_model[b]);
          core_bin_q.push_back(b);
        end
      end
      if (res_valid) n_valid++;
      if (res_valid && res_ready) begin
        n_res++;
        checks++;
        assert (res_q.size() != 0) else begin
          errors++;
          $error("FAIL result_unexpected observed=bin%0d expected=none", res_bin);
        end
        if (res_q.size() != 0) begin
          res_t e;
          e = res_q.pop_front();
          chk("res_bin", res_bin, 64'(e.bin));
          chk("res_T1", res_T1, e.t1);
          chk("res_T2", res_T2, e.t2);
        end
      end
      if (sweep_done) n_sweeps++;
      hold_prev = res_valid && !res_ready;
      held = {res_bin, res_T1, res_T2};
    end
  end

  task automatic write_coeff(input int a, input logic [15:0] v);
    @(posedge sys_clk); #1;
    cfg_we = 1; cfg_addr = 2'(a); cfg_coeff = v;
    @(posedge sys_clk); #1;
    cfg_we = 0;
    if (a < 4) tbl_model[a] = v;
  endtask

  task automatic launch(input logic [3:0] m, input int hang, input int d, input logic [15:0] salt);
    cur_mask = m; hang_bin = hang; core_delay = d; frame_salt = salt;
    start_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        start_q.push_back(i);
        if (i != hang) res_q.push_back('{i, t_val(i, 1, salt), t_val(i, 2, salt)});
      end
    end
    st0 = n_starts; rs0 = n_res; v0 = n_valid; sw0 = n_sweeps;
    @(posedge sys_clk); #1;
    frame_ready = 1; bin_mask = m; fp = cyc;
    @(posedge sys_clk); #1;
    frame_ready = 0; bin_mask = $urandom();
    @(negedge sys_clk);
    chk("accept_busy", busy, 1);
    chk("accept_no_overrun", overrun, 0);
    chk("accept_clears_timeout", timeout_err, 0);
  endtask

  task automatic finish_frame(input int budget);
    bit found = 0;
    int dc;
    for (int k = 0; k < budget; k++) begin
      if (sweep_done) begin found = 1; break; end
      @(negedge sys_clk);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL sweep_done_wait observed=none expected=pulse within %0d cycles", budget);
    end
    dc = cyc;
    if (found) begin
      chk("busy_at_done", busy, 1);
      if (cur_mask == 0) chk("empty_sweep_latency", 64'(dc - fp), 6);
      @(negedge sys_clk);
      chk("done_one_cycle", sweep_done, 0);
      chk("busy_after_done", {busy, core_enable}, 0);
    end
    chk("starts_left", 64'(start_q.size()), 0);
    chk("results_left", 64'(res_q.size()), 0);
    chk("sweep_count", 64'(n_sweeps - sw0), 1);
    if (cur_mask[0] && start_cyc.size() > 0) chk("bin0_latency", 64'(start_cyc[0] - fp), 3);
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (n_starts - st0 >= n) begin ok = 1; break; end
      @(negedge sys_clk);
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=%0d starts expected=%0d", tag, n_starts - st0, n);
    end
  endtask

  initial begin
    int a, sc;
    logic [15:0] salt;
    sys_rst_n = 0; frame_ready = 0; bin_mask = '0; cfg_we = 0; cfg_addr = '0;
    cfg_coeff = '0; res_ready = 1;
    for (int i = 0; i < 4; i++) tbl_model[i] = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_outputs", {core_enable, core_start, core_coeff, res_valid, res_bin, res_T1,
                          res_T2, busy, sweep_done, overrun, timeout_err}, 0);
    @(posedge sys_clk); #1 sys_rst_n = 1;

    // Full sweep, long core latency
    write_coeff(0, 16'h7A00); write_coeff(1, 16'h6C00);
    write_coeff(2, 16'h5000); write_coeff(3, 16'h2E00);
    launch(4'b1111, -1, 1026, 16'h0000);
    finish_frame(6000);
    chk("full_starts", 64'(n_starts - st0), 4);
    chk("full_results", 64'(n_res - rs0), 4);

    // Sparse mask
    launch(4'b0101, -1, 7, 16'($urandom()));
    finish_frame(200);
    chk("sparse_starts", 64'(n_starts - st0), 2);
    chk("sparse_results", 64'(n_res - rs0), 2);

    // Backpressure on the first result
    res_ready = 0;
    salt = 16'($urandom());
    launch(4'b1111, -1, 4, salt);
    a = 0;
    while (!res_valid && a < 200) begin @(negedge sys_clk); a++; end
    chk("bp_first_valid", res_valid, 1);
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_bin", res_bin, 0);
      chk("bp_T1", res_T1, t_val(0, 1, salt));
      chk("bp_T2", res_T2, t_val(0, 2, salt));
      chk("bp_no_start", 64'(n_starts - st0), 1);
    end
    @(posedge sys_clk); #1 res_ready = 1; a = cyc;
    wait_starts(2, 50, "bp_second_start");
    if (start_cyc.size() > 1) chk("bp_restart_latency", 64'(start_cyc[1] - a), 3);
    finish_frame(200);

    // Overrun while the core is busy
    launch(4'b0011, -1, 40, 16'($urandom()));
    wait_starts(1, 50, "ovr_first_start");
    repeat (5) @(negedge sys_clk);
    @(posedge sys_clk); #1 frame_ready = 1;
    @(posedge sys_clk); #1 frame_ready = 0;
    @(negedge sys_clk);
    chk("overrun_pulse", overrun, 1);
    @(negedge sys_clk);
    chk("overrun_one_cycle", overrun, 0);
    finish_frame(300);
    chk("ovr_results", 64'(n_results_delta()), 2);

    // Empty mask
    launch(4'b0000, -1, 1, 16'h0);
    finish_frame(20);
    chk("empty_no_valid", 64'(n_valid - v0), 0);

    // Core hangs on bin 1
    launch(4'b0011, 1, 5, 16'($urandom()));
    wait_starts(2, 100, "to_second_start");
    if (start_cyc.size() > 1) begin
      sc = start_cyc[1];
      while (cyc < sc + 2048) @(negedge sys_clk);
      chk("to_not_yet", timeout_err, 0);
      @(negedge sys_clk);
      chk("to_set", timeout_err, 1);
    end
    finish_frame(50);
    chk("to_results", 64'(n_res - rs0), 1);
    chk("to_sticky", timeout_err, 1);
    launch(4'b0000, -1, 1, 16'h0);
    finish_frame(20);

    // Randomized frames with random ready
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 1) write_coeff(j, 16'($urandom()));
      ready_mode = 1;
      launch(4'($urandom_range(0, 15)), -1, $urandom_range(1, 30), 16'($urandom()));
      finish_frame(2000);
      ready_mode = 0;
      @(posedge sys_clk); #1 res_ready = 1;
    end

    // Asynchronous reset mid-WAIT
    write_coeff(0, 16'($urandom()) | 16'h0001);
    launch(4'b0001, -1, 500, 16'($urandom()));
    wait_starts(1, 50, "rst_first_start");
    repeat (10) @(negedge sys_clk);
    #2 sys_rst_n = 0;
    #1 chk("async_reset_outputs", {core_enable, core_start, core_coeff, res_valid, res_bin,
                                   res_T1, res_T2, busy, sweep_done, overrun, timeout_err}, 0);
    start_q.delete(); res_q.delete(); core_bin_q.delete();
    for (int i = 0; i < 4; i++) tbl_model[i] = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1;
    launch(4'b0001, -1, 3, 16'($urandom()));
    finish_frame(100);
    chk("post_reset_results", 64'(n_res - rs0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic int n_results_delta();
    return n_res - rs0;
  endfunction

endmodule
